// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl
// Front end for a single-port RAM. A write channel and a read channel
// (valid/ready each) share the RAM port at one access per cycle. Read data
// returning from the RAM lands in a 3-entry response buffer that the
// consumer drains through its own valid/ready handshake.
//
// Ports
//   clka, rsta             clock shared with the RAM; async active-high reset
//   wr_valid/wr_ready      write request handshake, wr_addr/wr_data payload
//   rd_valid/rd_ready      read request handshake, rd_addr payload
//   rsp_valid/rsp_ready    read response handshake, rsp_data = buffer head
//   ram_ena/ram_wea/ram_addra/ram_dina   drive the RAM port
//   ram_douta              RAM read data, one cycle after a read is issued
module sp_ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta
);

  localparam int DEPTH = 3;

  logic                  last_gnt_q, last_gnt_d;   // 0 = write, 1 = read
  logic                  inflight_q, inflight_d;   // read issued last cycle
  logic [1:0]            wptr_q, wptr_d;
  logic [1:0]            rptr_q, rptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fifo_q [DEPTH];

  logic [2:0] occ;
  logic       rd_elig;
  logic       gnt_wr;
  logic       gnt_rd;
  logic       push;
  logic       pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    // Credit check counts the read already in the RAM pipeline so the buffer
    // can never be overrun; only registered terms, so no path from rsp_ready.
    occ     = {1'b0, cnt_q} + {2'b00, inflight_q};
    rd_elig = (occ < 3'd3);

    // Round-robin when both contend: last_gnt picks the other channel.
    gnt_wr  = wr_valid & (~(rd_valid & rd_elig) | last_gnt_q);
    gnt_rd  = rd_valid & rd_elig & (~wr_valid | ~last_gnt_q);

    wr_ready  = gnt_wr;
    rd_ready  = gnt_rd;
    ram_ena   = gnt_wr | gnt_rd;
    ram_wea   = gnt_wr;
    ram_addra = gnt_wr ? wr_addr : rd_addr;
    ram_dina  = wr_data;

    rsp_valid = (cnt_q != 2'd0);
    rsp_data  = fifo_q[0];
    if (rptr_q == 2'd1) begin
      rsp_data = fifo_q[1];
    end else if (rptr_q == 2'd2) begin
      rsp_data = fifo_q[2];
    end

    push = inflight_q;
    pop  = rsp_valid & rsp_ready;

    last_gnt_d = last_gnt_q;
    if (gnt_rd) begin
      last_gnt_d = 1'b1;
    end else if (gnt_wr) begin
      last_gnt_d = 1'b0;
    end
    inflight_d = gnt_rd;

    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;

    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      last_gnt_q <= 1'b1;
      inflight_q <= 1'b0;
      wptr_q     <= 2'd0;
      rptr_q     <= 2'd0;
      cnt_q      <= 2'd0;
    end else begin
      last_gnt_q <= last_gnt_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // RAM data is only valid in the cycle after a read grant; capture it then.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wptr_q == 2'(i)) begin
          fifo_q[i] <= ram_douta;
        end
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!rsta) begin
      assert (occ <= 3'd3);
    end
  end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
module tb_sp_ram_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          ram_ena, ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina, ram_douta;

  sp_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clka      (clk),
    .rsta      (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_douta (ram_douta)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one cycle read latency.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (ram_ena) begin
      if (ram_wea) mem[ram_addra] <= ram_dina;
      else         ram_douta      <= mem[ram_addra];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_rsp    = 0;
  int max_cnt  = 0;
  bit track    = 1'b0;

  logic [DW-1:0] model [1024];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_word;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected read data is queued at the read handshake from the
  // bench's own memory image, and popped when the consumer takes a response.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check1("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          exp_word = exp_q.pop_front();
          check32("rsp_data", rsp_data, exp_word);
          n_rsp++;
        end
      end
      if (wr_valid && wr_ready) model[wr_addr] = wr_data;
      if (rd_valid && rd_ready) exp_q.push_back(model[rd_addr]);
      check1("gnt_exclusive", wr_ready & rd_ready, 1'b0);
      check1("occ_bound", ({1'b0, dut.cnt_q} + {2'b00, dut.inflight_q}) <= 3'd3, 1'b1);
      if (track && int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    int  cyc;
    bit  hit;
    wr_valid = 1'b1;
    wr_addr  = AW'(a);
    wr_data  = d;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < 5) begin
      @(negedge clk);
      hit = wr_ready;
      step();
      cyc++;
    end
    if (!hit) check1("wr_timeout", 1'b0, 1'b1);
    wr_valid = 1'b0;
  endtask

  task automatic do_reads(input int base, input int n, input int budget, output int got);
    int cyc;
    bit hit;
    rd_valid = 1'b1;
    rd_addr  = AW'(base);
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      hit = rd_ready;
      step();
      if (hit) got++;
      rd_addr = AW'(base + got);
      cyc++;
    end
    rd_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    rsp_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      step();
      c++;
    end
    check32("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int got;
    int rsp_base;

    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check1 ("rst_wr_ready",  wr_ready,  1'b0);
    check1 ("rst_rd_ready",  rd_ready,  1'b0);
    check1 ("rst_rsp_valid", rsp_valid, 1'b0);
    check32("rst_rsp_data",  rsp_data,  32'h0);
    check1 ("rst_ram_ena",   ram_ena,   1'b0);
    check1 ("rst_ram_wea",   ram_wea,   1'b0);
    step();
    rst = 1'b0;
    step();

    // Write addr 5 then read it back
    wr_valid = 1'b1; wr_addr = 10'd5; wr_data = 32'hA5A50001;
    @(negedge clk);
    check1 ("w5_ram_ena", ram_ena, 1'b1);
    check1 ("w5_ram_wea", ram_wea, 1'b1);
    check32("w5_addra",   32'(ram_addra), 32'd5);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    check1("w5_ena_off", ram_ena, 1'b0);
    step();
    rd_valid = 1'b1; rd_addr = 10'd5; rsp_ready = 1'b1;
    @(negedge clk);
    check1("r5_rd_ready", rd_ready, 1'b1);
    check1("r5_ram_wea",  ram_wea,  1'b0);
    step();                              // E0
    rd_valid = 1'b0;
    @(negedge clk);
    check1("r5_rsp_e0", rsp_valid, 1'b0);
    step();                              // E1
    @(negedge clk);
    check1 ("r5_rsp_e1",  rsp_valid, 1'b1);
    check32("r5_rsp_data", rsp_data, 32'hA5A50001);
    step();
    @(negedge clk);
    check1("r5_rsp_gone", rsp_valid, 1'b0);

    // Contention from reset: W, R, W, R ...
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 10'd20; rd_addr = 10'd20;
    for (int k = 0; k < 8; k++) begin
      wr_data = 32'hC0DE0000 + DW'(k);
      @(negedge clk);
      check1("cont_wr_ready", wr_ready, (k % 2) == 0);
      check1("cont_rd_ready", rd_ready, (k % 2) == 1);
      step();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    drain(20);

    // Preload addresses used below through the write channel
    for (int a = 0; a < 5; a++)    do_write(a, 32'h1000_0000 + DW'(a));
    for (int a = 100; a < 116; a++) do_write(a, 32'h5000_0000 + DW'(a));
    for (int a = 200; a < 204; a++) do_write(a, 32'h2000_0000 + DW'(a));
    for (int a = 300; a < 303; a++) do_write(a, 32'h3000_0000 + DW'(a));

    // Back-pressure: only three reads accepted
    rsp_ready = 1'b0;
    do_reads(0, 5, 8, got);
    check32("bp_accepted", 32'(got), 32'd3);
    rd_valid = 1'b1; rd_addr = 10'd3;
    @(negedge clk);
    check1 ("bp_rd_ready", rd_ready, 1'b0);
    check32("bp_cnt",      32'(dut.cnt_q), 32'd3);
    step();
    rsp_ready = 1'b1;
    do_reads(3, 2, 20, got);
    check32("bp_resume", 32'(got), 32'd2);
    drain(20);

    // Streaming 16 reads
    rsp_base = n_rsp;
    max_cnt = 0;
    track = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      rd_valid = 1'b1; rd_addr = AW'(100 + k);
      @(negedge clk);
      check1("stream_rd_ready", rd_ready, 1'b1);
      if (k >= 2) check1("stream_rsp_valid", rsp_valid, 1'b1);
      step();
    end
    rd_valid = 1'b0;
    drain(20);
    track = 1'b0;
    check1 ("stream_max_cnt", max_cnt <= 2, 1'b1);
    check32("stream_count", 32'(n_rsp - rsp_base), 32'd16);

    // Push and pop in the same cycle with the buffer nearly full
    rsp_ready = 1'b0;
    do_reads(200, 3, 10, got);
    check32("pp_fill", 32'(got), 32'd3);
    step();
    rd_valid = 1'b1; rd_addr = 10'd203; rsp_ready = 1'b1;
    @(negedge clk);
    check32("pp_cnt_full", 32'(dut.cnt_q), 32'd3);
    check1 ("pp_rd_blocked", rd_ready, 1'b0);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check1 ("pp_rd_open", rd_ready, 1'b1);
    step();
    rd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check32("pp_cnt_pre", 32'(dut.cnt_q), 32'd2);
    check1 ("pp_inflight", dut.inflight_q, 1'b1);
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    check32("pp_cnt_post", 32'(dut.cnt_q), 32'd2);
    step();
    drain(20);

    // Reset mid-burst with cnt = 2 and a read in flight
    rsp_ready = 1'b0;
    do_reads(300, 3, 10, got);
    check1 ("mid_pre_valid",    rsp_valid, 1'b1);
    check1 ("mid_pre_inflight", dut.inflight_q, 1'b1);
    rst = 1'b1;
    #1;
    check1 ("mid_rsp_valid", rsp_valid, 1'b0);
    check32("mid_rsp_data",  rsp_data, 32'h0);
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check1("mid_no_stale", rsp_valid, 1'b0);
      step();
    end
    wr_valid = 1'b1; rd_valid = 1'b1;
    wr_addr = 10'd20; rd_addr = 10'd20; wr_data = 32'hBEEF0001;
    @(negedge clk);
    check1("mid_first_wr", wr_ready, 1'b1);
    check1("mid_first_rd", rd_ready, 1'b0);
    step();
    @(negedge clk);
    check1("mid_second_rd", rd_ready, 1'b1);
    step();
    wr_valid = 1'b0; rd_valid = 1'b0;
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
